// File: rtl/store_rmw_dm_pkg.sv
// Shared definitions for the load/store data-memory path: size encodings,
// FSM state encoding and the size decode helper.
package store_rmw_dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

    localparam int unsigned DATA_W = 32;

    // Both 2'b10 and 2'b11 mean a full word.
    function automatic size_e decode_size(input logic [1:0] enc);
        case (enc)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: overlays right-justified store data onto the
// old memory word according to size and byte offset.
module store_lane_merge
    import store_rmw_dm_pkg::*;
(
    input  logic [DATA_W-1:0] old_word_i,
    input  logic [DATA_W-1:0] data_i,
    input  size_e             size_i,
    input  logic [1:0]        byte_sel_i,
    output logic [DATA_W-1:0] merged_o
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       lane_we;
        logic [7:0] lane_src;

        // Halfword stores ignore byte_sel_i[0]: no misalignment handling.
        always_comb begin
            lane_we  = 1'b1;
            lane_src = data_i[8*gi +: 8];
            case (size_i)
                SZ_BYTE: begin
                    lane_we  = (byte_sel_i == 2'(gi));
                    lane_src = data_i[7:0];
                end
                SZ_HALF: begin
                    lane_we  = (byte_sel_i[1] == 1'(gi / 2));
                    lane_src = data_i[8*(gi % 2) +: 8];
                end
                default: begin
                    lane_we  = 1'b1;
                    lane_src = data_i[8*gi +: 8];
                end
            endcase
        end

        assign merged_o[8*gi +: 8] = lane_we ? lane_src : old_word_i[8*gi +: 8];
    end

endmodule

// File: rtl/store_rmw_dm.sv
// Store unit for the data memory: full words are written directly, byte and
// halfword stores do a read-modify-write of the containing word.
module store_rmw_dm
    import store_rmw_dm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [DATA_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        WByteEn_DM,
    output logic              st_done,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    size_e             size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merged;

    // Bit 2 of the size field carries no meaning for stores.
    logic unused_size_bit;
    assign unused_size_bit = WByteEn_DM[2];

    store_lane_merge u_merge (
        .old_word_i (mem_rdata),
        .data_i     (data_q),
        .size_i     (size_q),
        .byte_sel_i (addr_q[1:0]),
        .merged_o   (merged)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (st_valid) begin
                    addr_d = st_addr;
                    data_d = st_data;
                    size_d = decode_size(WByteEn_DM[1:0]);
                    if (size_d == SZ_WORD) begin
                        wdata_d = st_data;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_rvalid) begin
                    wdata_d = merged;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SZ_BYTE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    assign st_ready  = (state_q == ST_IDLE);
    assign mem_re    = (state_q == ST_READ);
    assign mem_we    = (state_q == ST_WRITE);
    assign st_done   = (state_q == ST_WRITE);
    assign mem_addr  = {addr_q[DATA_W-1:2], 2'b00};
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_rmw_dm.sv
// Directed and randomized checks of the store unit against a word-level
// reference of the byte/halfword/word store rules.
module tb_store_rmw_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  WByteEn_DM;
    logic        st_done;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_we;
    logic [31:0] mem_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    store_rmw_dm dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .WByteEn_DM (WByteEn_DM),
        .st_done    (st_done),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory word after the store, from masks and shifts.
    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] d,
                                             input logic [31:0] old, input logic [1:0] sz);
        int          sh;
        logic [31:0] mask;
        if (sz == 2'b00) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
            return (old & ~mask) | ((d & 32'h0000_00FF) << sh);
        end else if (sz == 2'b01) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
            return (old & ~mask) | ((d & 32'h0000_FFFF) << sh);
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                             input int dly, input logic [31:0] rd, input string nm);
        logic [31:0] exp_w;
        logic [31:0] exp_a;
        bit          is_word;
        exp_w   = ref_word(a, d, rd, sz[1:0]);
        exp_a   = a & 32'hFFFF_FFFC;
        is_word = sz[1];
        @(negedge clk);
        chk({nm, "/ready_before"}, st_ready, 1);
        st_valid = 1'b1; st_addr = a; st_data = d; WByteEn_DM = sz;
        @(negedge clk);
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; WByteEn_DM = 3'($urandom);
        if (is_word) begin
            chk({nm, "/sw_we"}, mem_we, 1);
            chk({nm, "/sw_done"}, st_done, 1);
            chk({nm, "/sw_no_re"}, mem_re, 0);
            chk({nm, "/sw_addr"}, mem_addr, exp_a);
            chk({nm, "/sw_wdata"}, mem_wdata, exp_w);
        end else begin
            chk({nm, "/read_re"}, mem_re, 1);
            chk({nm, "/read_we"}, mem_we, 0);
            chk({nm, "/read_addr"}, mem_addr, exp_a);
            chk({nm, "/read_ready"}, st_ready, 0);
            for (int i = 1; i <= dly; i++) begin
                @(negedge clk);
                chk({nm, "/wait_re"}, mem_re, 0);
                chk({nm, "/wait_we"}, mem_we, 0);
                chk({nm, "/wait_ready"}, st_ready, 0);
                chk({nm, "/wait_addr"}, mem_addr, exp_a);
                if (i == dly) begin
                    mem_rvalid = 1'b1; mem_rdata = rd;
                end else begin
                    mem_rdata = $urandom;
                end
            end
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            chk({nm, "/rmw_we"}, mem_we, 1);
            chk({nm, "/rmw_done"}, st_done, 1);
            chk({nm, "/rmw_re"}, mem_re, 0);
            chk({nm, "/rmw_addr"}, mem_addr, exp_a);
            chk({nm, "/rmw_wdata"}, mem_wdata, exp_w);
        end
        @(negedge clk);
        chk({nm, "/after_we"}, mem_we, 0);
        chk({nm, "/after_done"}, st_done, 0);
        chk({nm, "/after_ready"}, st_ready, 1);
        $display("store %s addr=%h data=%h size=%0d dly=%0d old=%h -> expect wdata %h",
                 nm, a, d, sz, dly, rd, exp_w);
    endtask

    initial begin
        logic [31:0] wq_data[$];
        logic [31:0] wq_addr[$];
        int          wq_cyc[$];
        int          acc_cyc[$];
        int          re_seen;
        bit          pend_rv, drop_next, switched;

        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; WByteEn_DM = '0;
        mem_rdata = '0; mem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset/ready", st_ready, 1);
        chk("reset/done", st_done, 0);
        chk("reset/re", mem_re, 0);
        chk("reset/we", mem_we, 0);
        chk("reset/addr", mem_addr, 0);
        chk("reset/wdata", mem_wdata, 0);
        rst = 1'b0;

        run_store(32'h0000_0104, 32'hDEAD_BEEF, 3'b010, 1, 32'h0, "sw_0x104");
        run_store(32'h0000_0203, 32'h0000_00AA, 3'b000, 1, 32'h1122_3344, "sb_0x203");
        run_store(32'h0000_0302, 32'h0000_BEEF, 3'b001, 1, 32'h1122_3344, "sh_0x302");
        run_store(32'h0000_0303, 32'h0000_BEEF, 3'b001, 2, 32'h1122_3344, "sh_0x303");
        run_store(32'h0000_0301, 32'h0000_BEEF, 3'b001, 1, 32'h1122_3344, "sh_0x301");
        run_store(32'h0000_0208, 32'h1234_5655, 3'b000, 4, 32'hCAFE_F00D, "sb_delay4");
        run_store(32'h0000_0411, 32'hFFFF_FF5A, 3'b100, 1, 32'h0BAD_BEEF, "sb_bit2");
        run_store(32'h0000_0413, 32'h0102_0304, 3'b111, 1, 32'h0, "sw_size11");

        // Reset while waiting for read data, then a stale mem_rvalid.
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h0000_040C; st_data = 32'h0000_0077; WByteEn_DM = 3'b000;
        @(negedge clk);
        st_valid = 1'b0;
        @(negedge clk);
        chk("rstmid/wait_ready", st_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid/ready", st_ready, 1);
        chk("rstmid/we", mem_we, 0);
        chk("rstmid/re", mem_re, 0);
        chk("rstmid/addr", mem_addr, 0);
        chk("rstmid/wdata", mem_wdata, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rstmid/late_rv_we", mem_we, 0);
        chk("rstmid/late_rv_ready", st_ready, 1);
        @(negedge clk);
        chk("rstmid/late_rv_we2", mem_we, 0);
        chk("rstmid/late_rv_wdata", mem_wdata, 0);
        $display("reset-in-WAIT sequence complete");

        // Two byte stores with st_valid held high throughout.
        re_seen = 0; pend_rv = 1'b0; drop_next = 1'b0; switched = 1'b0;
        st_valid = 1'b1; st_addr = 32'h0000_0501; st_data = 32'h0000_00C3; WByteEn_DM = 3'b000;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (mem_re) re_seen++;
            if (mem_we) begin
                wq_data.push_back(mem_wdata);
                wq_addr.push_back(mem_addr);
                wq_cyc.push_back(cyc);
            end
            mem_rvalid = 1'b0;
            if (pend_rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (re_seen == 1) ? 32'hA0A1_A2A3 : 32'hB0B1_B2B3;
                pend_rv    = 1'b0;
            end
            if (mem_re) pend_rv = 1'b1;
            if (drop_next) begin
                st_valid = 1'b0; drop_next = 1'b0;
            end
            if (acc_cyc.size() == 1 && !switched) begin
                st_addr = 32'h0000_0602; st_data = 32'h0000_005E; switched = 1'b1;
            end
            if (st_ready && st_valid) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() == 2) drop_next = 1'b1;
            end
            @(negedge clk);
        end
        chk("b2b/accepts", acc_cyc.size(), 2);
        chk("b2b/reads", re_seen, 2);
        chk("b2b/writes", wq_data.size(), 2);
        if (acc_cyc.size() == 2 && wq_data.size() == 2) begin
            chk("b2b/second_accept_after_write", acc_cyc[1], wq_cyc[0] + 1);
            chk("b2b/wdata0", wq_data[0], ref_word(32'h0000_0501, 32'h0000_00C3, 32'hA0A1_A2A3, 2'b00));
            chk("b2b/addr0", wq_addr[0], 32'h0000_0500);
            chk("b2b/wdata1", wq_data[1], ref_word(32'h0000_0602, 32'h0000_005E, 32'hB0B1_B2B3, 2'b00));
            chk("b2b/addr1", wq_addr[1], 32'h0000_0600);
            $display("back-to-back: accepts at %0d,%0d writes at %0d,%0d",
                     acc_cyc[0], acc_cyc[1], wq_cyc[0], wq_cyc[1]);
        end

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rdd, rold;
            logic [2:0]  rsz;
            int          rdl;
            ra = $urandom; rdd = $urandom; rold = $urandom;
            rsz = 3'($urandom);
            rdl = int'($urandom_range(1, 5));
            run_store(ra, rdd, rsz, rdl, rold, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
